// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Bridges the cache's 256-bit line port to a 64-bit burst memory.
//   Each line request becomes a 4-beat burst. Beat 0 is line bits [63:0].
//   Read beats are assembled into dfp_rdata. Write beats are replayed from a
//   latched copy of dfp_wdata.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   dfp_addr         line address from the cache (bits [4:0] ignored)
//   dfp_read/write   level requests, held until dfp_resp
//   dfp_wdata        write line, valid while dfp_write is high
//   dfp_rdata        assembled read line (register)
//   dfp_resp         one-cycle completion pulse
//   burst_addr       line-aligned address {addr[31:5], 5'b0}
//   burst_read       read burst request, held until burst_ready
//   burst_write      write beat valid
//   burst_wdata      current write beat
//   burst_ready      memory accepts the read request or write beat this cycle
//   burst_rdata      read beat
//   burst_rvalid     read beat valid (in order 0..3, gaps allowed)
//   dbg_state        current FSM state, for observation only
//
// Handshake: a read request or write beat transfers in any cycle where
// burst_read/burst_write and burst_ready are both high. The adapter holds
// burst_addr/burst_wdata stable until that transfer. Read beats have no
// back-pressure: every burst_rvalid in RD_DATA is taken.
//
// Build option: CACHELINE_ADAPTER_POSTED_WRITE_EN
//   When defined, a write is acknowledged on the cycle after it is accepted
//   and drains in the background. New requests wait in place until the drain
//   has finished, so ordering is kept.

module cacheline_adapter (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  dfp_addr,
   input  logic         dfp_read,
   input  logic         dfp_write,
   input  logic [255:0] dfp_wdata,
   output logic [255:0] dfp_rdata,
   output logic         dfp_resp,
   output logic [31:0]  burst_addr,
   output logic         burst_read,
   output logic         burst_write,
   output logic [63:0]  burst_wdata,
   input  logic         burst_ready,
   input  logic [63:0]  burst_rdata,
   input  logic         burst_rvalid,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_DATA = 3'd3,
      RESP    = 3'd4
   } state_t;

   state_t        state;
   logic [1:0]    cnt;
   logic [1:0]    cnt_nxt;
   logic [255:0]  wbuf;

   assign cnt_nxt   = cnt + 2'd1;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         wbuf        <= '0;
         dfp_rdata   <= '0;
         dfp_resp    <= 1'b0;
         burst_addr  <= '0;
         burst_read  <= 1'b0;
         burst_write <= 1'b0;
         burst_wdata <= '0;
      end else begin
         dfp_resp <= 1'b0;
         case (state)
            IDLE: begin
               // Write wins if both are raised; the read is dropped.
               if (dfp_write) begin
                  burst_addr  <= {dfp_addr[31:5], 5'b0};
                  wbuf        <= dfp_wdata;
                  burst_wdata <= dfp_wdata[63:0];
                  burst_write <= 1'b1;
                  cnt         <= 2'd0;
                  state       <= WR_DATA;
`ifdef CACHELINE_ADAPTER_POSTED_WRITE_EN
                  // Line is safely captured in wbuf, so acknowledge now.
                  dfp_resp    <= 1'b1;
`endif
               end else if (dfp_read) begin
                  burst_addr  <= {dfp_addr[31:5], 5'b0};
                  burst_read  <= 1'b1;
                  cnt         <= 2'd0;
                  state       <= RD_ADDR;
               end
            end

            RD_ADDR: begin
               if (burst_ready) begin
                  burst_read <= 1'b0;
                  state      <= RD_DATA;
               end
            end

            RD_DATA: begin
               // Beats land straight in the output register, so the previous
               // line stays visible until this read's first beat arrives.
               if (burst_rvalid) begin
                  dfp_rdata[{cnt, 6'd0} +: 64] <= burst_rdata;
                  cnt <= cnt_nxt;
                  if (cnt == 2'd3) begin
                     dfp_resp <= 1'b1;
                     state    <= RESP;
                  end
               end
            end

            WR_DATA: begin
               if (burst_ready) begin
                  cnt <= cnt_nxt;
                  if (cnt == 2'd3) begin
                     burst_write <= 1'b0;
                     burst_wdata <= '0;
`ifdef CACHELINE_ADAPTER_POSTED_WRITE_EN
                     // Already acknowledged; pending requests get sampled next.
                     state       <= IDLE;
`else
                     dfp_resp    <= 1'b1;
                     state       <= RESP;
`endif
                  end else begin
                     burst_wdata <= wbuf[{cnt_nxt, 6'd0} +: 64];
                  end
               end
            end

            // The request is still high here; going straight to IDLE without
            // sampling keeps it from being serviced twice.
            RESP: state <= IDLE;

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  burst_addr;
   logic         burst_read;
   logic         burst_write;
   logic [63:0]  burst_wdata;
   logic         burst_ready;
   logic [63:0]  burst_rdata;
   logic         burst_rvalid;
   logic [2:0]   dbg_state;

   int total = 0;
   int bad   = 0;
   logic [255:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   cacheline_adapter dut (
      .clk          (clk),
      .rst          (rst),
      .dfp_addr     (dfp_addr),
      .dfp_read     (dfp_read),
      .dfp_write    (dfp_write),
      .dfp_wdata    (dfp_wdata),
      .dfp_rdata    (dfp_rdata),
      .dfp_resp     (dfp_resp),
      .burst_addr   (burst_addr),
      .burst_read   (burst_read),
      .burst_write  (burst_write),
      .burst_wdata  (burst_wdata),
      .burst_ready  (burst_ready),
      .burst_rdata  (burst_rdata),
      .burst_rvalid (burst_rvalid),
      .dbg_state    (dbg_state)
   );

   // ---------------- helpers ----------------
   // Inputs are driven and outputs sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_resp"},  dfp_resp,    0);
      chk({tag, "_bread"}, burst_read,  0);
      chk({tag, "_bwr"},   burst_write, 0);
      chk({tag, "_baddr"}, burst_addr,  0);
      chk({tag, "_bwd"},   burst_wdata, 0);
      chk({tag, "_rdata"}, dfp_rdata,   0);
      chk({tag, "_state"}, dbg_state,   0);
   endtask

   // ---------------- driver: line read ----------------
   // Entered and left on a falling edge. g1..g3 are idle cycles before beats
   // 1..3; extra is the number of cycles the request waits before sampling.
   task automatic rd_line(input logic [31:0] addr, input logic [255:0] line,
                          input int g1, input int g2, input int g3, input int extra);
      int cyc;
      int g;
      logic [255:0] exp;
      dfp_addr    = addr;
      dfp_read    = 1'b1;
      burst_ready = 1'b1;
      exp_q.push_back(line);
      cyc = 0;
      repeat (extra) begin
         step(); cyc++;
         chk("rd_wait_idle", {burst_read, burst_write}, 0);
      end
      step(); cyc++;
      chk("rd_req",  burst_read, 1);
      chk("rd_addr", burst_addr, {addr[31:5], 5'b0});
      step(); cyc++;
      chk("rd_req_drop", burst_read, 0);
      for (int i = 0; i < 4; i++) begin
         g = (i == 1) ? g1 : (i == 2) ? g2 : (i == 3) ? g3 : 0;
         burst_rvalid = 1'b0;
         repeat (g) begin step(); cyc++; end
         burst_rvalid = 1'b1;
         burst_rdata  = line[64*i +: 64];
         step(); cyc++;
      end
      burst_rvalid = 1'b0;
      burst_rdata  = '0;
      chk("rd_resp",    dfp_resp, 1);
      chk("rd_latency", cyc, extra + 6 + g1 + g2 + g3);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         chk("rd_line", dfp_rdata, exp);
      end else begin
         chk("rd_sb_empty", 1, 0);
      end
      dfp_read = 1'b0;
      step();
      chk("rd_resp_pulse", dfp_resp,  0);
      chk("rd_hold",       dfp_rdata, line);
   endtask

   // ---------------- driver: line write ----------------
   // rdy gives burst_ready per cycle from T+1; beyond npat entries it is 1.
   // Returns on the falling edge after the last accepted beat.
   task automatic wr_line(input logic [31:0] addr, input logic [255:0] line,
                          input logic [7:0] rdy, input int npat, output int cyc);
      int acc;
      int k;
      logic [255:0] exp;
      dfp_addr  = addr;
      dfp_write = 1'b1;
      dfp_wdata = line;
      for (int i = 0; i < 4; i++) exp_q.push_back({192'b0, line[64*i +: 64]});
      acc = 0;
      k   = 0;
      cyc = 0;
      step(); cyc++;
`ifdef CACHELINE_ADAPTER_POSTED_WRITE_EN
      chk("wr_post_resp", dfp_resp, 1);
      dfp_write = 1'b0;
`endif
      while (acc < 4 && cyc < 40) begin
         burst_ready = (k < npat) ? rdy[k] : 1'b1;
         k++;
         chk("wr_valid", burst_write, 1);
         chk("wr_addr",  burst_addr,  {addr[31:5], 5'b0});
         if (exp_q.size() > 0) begin
            exp = exp_q[0];
            chk("wr_beat", burst_wdata, {192'b0, exp[63:0]});
            if (burst_ready) begin
               void'(exp_q.pop_front());
               acc++;
            end
         end else begin
            chk("wr_sb_empty", 1, 0);
            acc = 4;
         end
         step(); cyc++;
      end
      chk("wr_all_accepted", acc, 4);
      burst_ready = 1'b1;
      chk("wr_done_valid", burst_write, 0);
`ifdef CACHELINE_ADAPTER_POSTED_WRITE_EN
      chk("wr_post_no_resp", dfp_resp, 0);
`else
      chk("wr_resp", dfp_resp, 1);
`endif
      dfp_write = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wcyc;
      rst          = 1'b1;
      dfp_addr     = '0;
      dfp_read     = 1'b0;
      dfp_write    = 1'b0;
      dfp_wdata    = '0;
      burst_ready  = 1'b0;
      burst_rdata  = '0;
      burst_rvalid = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();

      // 1) basic read, back-to-back beats
      rd_line(32'h0000_1234,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 0, 0);

      // 2) write with ready pattern 1,0,1,0,1,1
      wr_line(32'h8000_0040,
              {64'hD4D4_0000_0000_0004, 64'hC3C3_0000_0000_0003,
               64'hB2B2_0000_0000_0002, 64'hA1A1_0000_0000_0001},
              8'b0011_0101, 6, wcyc);
      step();
      chk("wr_resp_pulse", dfp_resp, 0);

      // 3) spurious rvalid in IDLE, then read with gaps 0,3,1
      burst_rvalid = 1'b1;
      burst_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      burst_rvalid = 1'b0;
      chk("spur_idle", dbg_state, 0);
      rd_line(32'h0001_00A0,
              {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()}, 0, 3, 1, 0);

      // 4) write-back then immediate read
      wr_line(32'h0000_2000, {8{$urandom()}}, 8'hFF, 0, wcyc);
`ifndef CACHELINE_ADAPTER_POSTED_WRITE_EN
      chk("wr_latency", wcyc, 5);
      rd_line(32'h0000_3000, {4{64'h0123_4567_89AB_CDEF}}, 0, 0, 0, 1);
`else
      rd_line(32'h0000_3000, {4{64'h0123_4567_89AB_CDEF}}, 0, 0, 0, 0);
`endif

      // 5) reset after beat 2 of a read
      dfp_addr    = 32'h4000_0080;
      dfp_read    = 1'b1;
      burst_ready = 1'b1;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         burst_rvalid = 1'b1;
         burst_rdata  = 64'h5A5A_0000_0000_0000 | 64'(i + 1);
         step();
      end
      burst_rvalid = 1'b0;
      rst      = 1'b1;
      dfp_read = 1'b0;
      step();
      chk_all_zero("midrst");
      rst = 1'b0;
      repeat (3) begin
         step();
         chk("midrst_no_resp", dfp_resp, 0);
      end
      rd_line(32'h4000_0080, {4{$urandom_range(32'h7FFF_FFFF, 0), 32'h0}}, 1, 0, 2, 0);

`ifdef CACHELINE_ADAPTER_POSTED_WRITE_EN
      // 6) posted write followed by a read at T+2
      dfp_addr    = 32'h0000_0100;
      dfp_write   = 1'b1;
      dfp_wdata   = {64'h4, 64'h3, 64'h2, 64'h1};
      burst_ready = 1'b1;
      step();
      chk("post_resp_t1", dfp_resp, 1);
      chk("post_b0", burst_wdata, 64'h1);
      dfp_write = 1'b0;
      step();
      dfp_addr = 32'h0000_0200;
      dfp_read = 1'b1;
      chk("post_b1", burst_wdata, 64'h2);
      step();
      chk("post_b2", burst_wdata, 64'h3);
      chk("post_rd_wait2", burst_read, 0);
      step();
      chk("post_b3", burst_wdata, 64'h4);
      chk("post_rd_wait3", burst_read, 0);
      chk("post_no_dup_resp", dfp_resp, 0);
      rd_line(32'h0000_0200, {4{64'hFEED_FACE_0000_0001}}, 0, 0, 0, 1);
`endif

      step();
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
